// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with skid buffer.
// in_ready is decoded from registered state only.
module pipe_skid_reg #(
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  // Initialisers give reset values from time zero.
  logic [DATA_W-1:0] r_main   = '0;
  logic [DATA_W-1:0] r_skid   = '0;
  logic              r_main_v = 1'b0;
  logic              r_skid_v = 1'b0;
  logic [CNT_W-1:0]  r_stall  = '0;
  logic [CNT_W-1:0]  r_xfer   = '0;

  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_stall;
  logic [1:0] w_state;

  assign w_state    = {r_skid_v, r_main_v};
  assign w_in_xfer  = in_valid & ~r_skid_v;
  assign w_out_xfer = r_main_v & out_ready;
  assign w_stall    = r_main_v & ~out_ready;

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = r_main;
  assign occupancy = {r_skid_v, r_main_v & ~r_skid_v};
  assign stall_cnt = r_stall;
  assign xfer_cnt  = r_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_xfer  <= '0;
    end else begin
      if (w_stall && (r_stall != {CNT_W{1'b1}}))
        r_stall <= r_stall + CNT_W'(1);
      if (w_out_xfer && !flush && (r_xfer != {CNT_W{1'b1}}))
        r_xfer <= r_xfer + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else begin
      unique case (w_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main   <= in_data;
            r_main_v <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= in_data;
          end else if (w_out_xfer) begin
            r_main   <= '0;
            r_main_v <= 1'b0;
          end else if (w_in_xfer) begin
            r_skid   <= in_data;
            r_skid_v <= 1'b1;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_main   <= r_skid;
            r_skid   <= '0;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          // Skid without main is unreachable; recover to empty.
          r_main   <= '0;
          r_skid   <= '0;
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, meaning payload width in bits (instr, pc, rs, rt, ext packed).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the performance counters.
REQ-003 The block SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  synchronous pipeline flush (bubble insert).
REQ-006 The block SHALL have port in_valid  input  1  upstream payload present.
REQ-007 The block SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 The block SHALL have port in_ready  output  1  block accepts payload this cycle.
REQ-009 The block SHALL have port out_valid  output  1  downstream payload present.
REQ-010 The block SHALL have port out_data  output  DATA_W  downstream payload.
REQ-011 The block SHALL have port out_ready  input  1  downstream accepts payload this cycle.
REQ-012 The block SHALL have port occupancy  output  2  entries held (0, 1 or 2).
REQ-013 The block SHALL have port stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-014 The block SHALL have port xfer_cnt  output  CNT_W  completed output transfers.

Function
REQ-015 Storage SHALL be one main register plus one skid register, each with a valid bit; state EMPTY (none), ONE (main only), FULL (main and skid).
REQ-016 out_valid SHALL equal main valid; out_data SHALL be the main register; in_ready SHALL equal NOT skid valid, decoded from registers only (no combinational path from out_ready).
REQ-017 Input transfer SHALL occur when in_valid=1 and in_ready=1; output transfer when out_valid=1 and out_ready=1.
REQ-018 EMPTY: input transfer -> main<=in_data, ONE; else stay EMPTY.
REQ-019 ONE: input and output transfer -> main<=in_data, stay ONE; output only -> EMPTY; input only -> skid<=in_data, FULL; neither -> hold.
REQ-020 FULL: in_ready=0; output transfer -> main<=skid, skid cleared, ONE; else hold all.
REQ-021 Latency SHALL be one cycle from input transfer to out_valid when the block is EMPTY or drains in that cycle; throughput one payload per cycle with out_ready held high.
REQ-022 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated except on flush/reset.
REQ-023 Any register whose valid bit is 0 SHALL hold all-zero data, so out_data=0 (NOP bubble) whenever out_valid=0.
REQ-024 flush=1 SHALL on the next edge clear both valid bits and data to zero, discard any same-cycle input, and not count a same-cycle output transfer in xfer_cnt.
REQ-025 occupancy SHALL be 0/1/2 for EMPTY/ONE/FULL.
REQ-026 stall_cnt SHALL increment on each cycle with out_valid=1 and out_ready=0, xfer_cnt on each output transfer; both saturate at 2^CNT_W-1 and are not cleared by flush.

Reset
REQ-027 reset=1 SHALL override flush and all handshakes: state EMPTY, both registers zero, out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0, xfer_cnt=0 after the edge.
REQ-028 Reset asserted mid-operation (ONE or FULL) SHALL discard held payloads with no output transfer counted.
REQ-029 All outputs SHALL be zero/reset values from time zero in simulation before the first reset edge.

Verification
REQ-030 DATA_W=32; reset, then in_valid=1 with 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, xfer_cnt=3, occupancy never 2.
REQ-031 out_ready=0, push 0xA1, 0xA2 -> occupancy=2, in_ready=0, 0xA3 held off; out_ready=1 -> outputs 0xA1,0xA2,0xA3 in order.
REQ-032 FULL with out_ready=0 for 5 cycles -> stall_cnt=5, in_ready=0 throughout, out_data stable 0xA1.
REQ-033 FULL, flush=1 with in_valid=1 data 0xFF -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1; 0xFF never appears.
REQ-034 CNT_W=2, 5 output transfers -> xfer_cnt=3 (saturated).
REQ-035 reset and flush asserted together in state ONE -> all counters 0, occupancy=0, out_data=0.
